// File: rtl/ber_pkg.sv
// Shared definitions for the BER test sequencer: FSM state encodings,
// default counter width and the latency counter width.
package ber_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int CNT_W_DEF = 32;
  // PIPE_LATENCY tops out at 255, so 8 bits cover every legal load value
  localparam int LAT_W     = 8;

endpackage

// File: rtl/ber_test_seq_down_counter.sv
// Loadable down-counter with a zero flag. Decrement stops at zero; load
// has priority over decrement. Used for the FLUSH/DRAIN latency window
// and for the RUN-state watchdog.
module seq_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: load wins, otherwise count down and hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                  cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ber_test_seq.sv
// BER test sequencer: flushes the PRBS pipeline, counts checked bits and
// errors up to a target or error limit, drains the pipeline, then reports.
// Optional feature macro: BER_SEQ_TIMEOUT_EN adds a RUN-state watchdog
// and the timeout output.
module ber_test_seq
  import ber_pkg::*;
#(
  parameter int PIPE_LATENCY = 4,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] target_bits,
  input  logic [CNT_W-1:0] err_limit,
  input  logic             chk_bit_valid,
  input  logic             chk_bit_error,
  output logic             gen_en,
  output logic             chk_en,
  output logic             busy,
  output logic             done,
  output logic             err_abort,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
`ifdef BER_SEQ_TIMEOUT_EN
  output logic             timeout,
`endif
  output logic [2:0]       state_o
);

  // FLUSH and DRAIN each last exactly PIPE_LATENCY cycles: load N-1, leave on zero
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(PIPE_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_q, bit_d, err_q, err_d;
  logic [CNT_W-1:0] tgt_q, tgt_d, lim_q, lim_d;
  logic             abort_q, abort_d;
  logic             lat_load, lat_dec, lat_zero;
  logic             lim_hit;

`ifdef BER_SEQ_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYC - 1);
  logic timeout_q, timeout_d;
  logic wd_load, wd_dec, wd_zero;
`endif

  seq_down_counter #(.W(LAT_W)) u_lat (
    .clk        (clk),
    .rst        (rst),
    .load_i     (lat_load),
    .dec_i      (lat_dec),
    .load_val_i (LAT_LOAD),
    .zero_o     (lat_zero)
  );

`ifdef BER_SEQ_TIMEOUT_EN
  seq_down_counter #(.W(WD_W)) u_wd (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wd_load),
    .dec_i      (wd_dec),
    .load_val_i (WD_LOAD),
    .zero_o     (wd_zero)
  );
`endif

  // next-state, counter updates and latency/watchdog control
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    err_d    = err_q;
    tgt_d    = tgt_q;
    lim_d    = lim_q;
    abort_d  = abort_q;
    lat_load = 1'b0;
    lat_dec  = 1'b0;
    lim_hit  = 1'b0;
`ifdef BER_SEQ_TIMEOUT_EN
    timeout_d = timeout_q;
    wd_load   = 1'b0;
    wd_dec    = 1'b0;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && target_bits != '0) begin
          state_d  = S_FLUSH;
          bit_d    = '0;
          err_d    = '0;
          tgt_d    = target_bits;
          lim_d    = err_limit;
          abort_d  = 1'b0;
          lat_load = 1'b1;
`ifdef BER_SEQ_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
      end
      S_FLUSH: begin
        if (stop) state_d = S_IDLE;
        else if (lat_zero) begin
          state_d = S_RUN;
`ifdef BER_SEQ_TIMEOUT_EN
          wd_load = 1'b1;
`endif
        end else lat_dec = 1'b1;
      end
      S_RUN: begin
        if (stop) state_d = S_IDLE;
        else begin
          // never count past the target; both counters saturate
          if (chk_bit_valid && bit_q != tgt_q) begin
            if (bit_q != '1) bit_d = bit_q + 1'b1;
            if (chk_bit_error && err_q != '1) err_d = err_q + 1'b1;
          end
          lim_hit = (lim_q != '0) && (err_d >= lim_q);
          if (bit_d == tgt_q || lim_hit) begin
            state_d  = S_DRAIN;
            abort_d  = lim_hit;
            lat_load = 1'b1;
          end
`ifdef BER_SEQ_TIMEOUT_EN
          else if (!chk_bit_valid && wd_zero) begin
            state_d   = S_DRAIN;
            timeout_d = 1'b1;
            lat_load  = 1'b1;
          end
          // any valid bit restarts the idle window
          wd_load = chk_bit_valid;
          wd_dec  = !chk_bit_valid;
`endif
        end
      end
      S_DRAIN: begin
        if (stop) state_d = S_IDLE;
        else if (lat_zero) state_d = S_DONE;
        else lat_dec = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and run registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      err_q   <= '0;
      tgt_q   <= '0;
      lim_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      err_q   <= err_d;
      tgt_q   <= tgt_d;
      lim_q   <= lim_d;
      abort_q <= abort_d;
    end
  end

`ifdef BER_SEQ_TIMEOUT_EN
  // sticky timeout flag, cleared on start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) timeout_q <= 1'b0;
    else     timeout_q <= timeout_d;
  end
  assign timeout = timeout_q;
`endif

  assign gen_en    = (state_q == S_FLUSH) || (state_q == S_RUN);
  assign chk_en    = (state_q == S_RUN);
  assign busy      = (state_q == S_FLUSH) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign err_abort = abort_q;
  assign bit_count = bit_q;
  assign err_count = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_ber_test_seq.sv
// Directed bench for ber_test_seq with PIPE_LATENCY=4, TIMEOUT_CYC=16.
module tb_ber_test_seq;

  logic        clk = 1'b0;
  logic        rst, start, stop, vld, err;
  logic [31:0] target_bits, err_limit;
  logic        gen_en, chk_en, busy, done, err_abort;
  logic [31:0] bit_count, err_count;
  logic [2:0]  state_o;
`ifdef BER_SEQ_TIMEOUT_EN
  logic        timeout;
`endif

  int n_total = 0;
  int n_pass  = 0;

  ber_test_seq #(.PIPE_LATENCY(4), .CNT_W(32), .TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stop          (stop),
    .target_bits   (target_bits),
    .err_limit     (err_limit),
    .chk_bit_valid (vld),
    .chk_bit_error (err),
    .gen_en        (gen_en),
    .chk_en        (chk_en),
    .busy          (busy),
    .done          (done),
    .err_abort     (err_abort),
    .bit_count     (bit_count),
    .err_count     (err_count),
`ifdef BER_SEQ_TIMEOUT_EN
    .timeout       (timeout),
`endif
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic launch(input logic [31:0] tgt, input logic [31:0] lim);
    target_bits = tgt;
    err_limit   = lim;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; vld = 0; err = 0;
    target_bits = '0; err_limit = '0;
    #3;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_outs", {27'd0, gen_en, chk_en, busy, done, err_abort}, 0);
    chk("rst_bits", bit_count, 0);
    chk("rst_errs", err_count, 0);
    tick(); tick();
    #2 rst = 1'b0;
    tick();

    // error-free run, target 100; valid held through FLUSH must be ignored
    vld = 1'b1;
    launch(100, 0);
    chk("flush_state", 32'(state_o), 1);
    chk("flush_en", {30'd0, gen_en, chk_en}, 2);
    repeat (3) tick();
    chk("flush_len", 32'(state_o), 1);
    tick();
    chk("run_entry", 32'(state_o), 2);
    chk("run_en", {30'd0, gen_en, chk_en}, 3);
    chk("flush_ignored", bit_count, 0);
    repeat (99) tick();
    chk("run_99", 32'(state_o), 2);
    tick();
    chk("drain_entry", 32'(state_o), 3);
    chk("drain_gen", 32'(gen_en), 0);
    chk("bits_100", bit_count, 100);
    repeat (3) tick();
    chk("drain_len", 32'(state_o), 3);
    tick();
    chk("done_state", {29'd0, done, busy, err_abort}, 4);
    chk("done_bits", bit_count, 100);
    chk("done_errs", err_count, 0);

    // errors on every 10th bit, limit 3
    vld = 1'b0;
    launch(1000, 3);
    chk("restart_clear", bit_count, 0);
    repeat (4) tick();
    for (int i = 1; i <= 30; i++) begin
      vld = 1'b1;
      err = (i % 10 == 0);
      tick();
      if (i == 29) chk("lim_29_state", 32'(state_o), 2);
    end
    vld = 0; err = 0;
    chk("lim_drain", 32'(state_o), 3);
    repeat (4) tick();
    chk("lim_done", 32'(done), 1);
    chk("lim_abort", 32'(err_abort), 1);
    chk("lim_errs", err_count, 3);
    chk("lim_bits", bit_count, 30);

    // stop in the second RUN cycle
    launch(50, 0);
    chk("start_clr_abort", 32'(err_abort), 0);
    repeat (4) tick();
    vld = 1'b1;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_idle", 32'(state_o), 0);
    chk("stop_gen", 32'(gen_en), 0);
    chk("stop_hold", bit_count, 1);
    tick();
    chk("idle_hold", bit_count, 1);

    // same-cycle start+stop in RUN, then zero target start
    vld = 1'b0;
    launch(5, 0);
    chk("restart_clr2", bit_count, 0);
    repeat (4) tick();
    chk("run2", 32'(state_o), 2);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_idle", 32'(state_o), 0);
    launch(0, 0);
    chk("zero_tgt_idle", {29'd0, state_o}, 0);
    chk("zero_tgt_busy", 32'(busy), 0);

    // start while busy is ignored; bits beyond target not counted
    launch(3, 0);
    target_bits = 100;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start", 32'(state_o), 1);
    repeat (3) tick();
    vld = 1'b1;
    repeat (3) tick();
    chk("tgt3_drain", 32'(state_o), 3);
    chk("tgt3_bits", bit_count, 3);
    repeat (4) tick();
    chk("tgt3_done", 32'(state_o), 4);
    chk("tgt3_nocount", bit_count, 3);

    // target and limit hit together -> abort; then stop in DRAIN
    vld = 1'b0;
    launch(2, 2);
    repeat (4) tick();
    vld = 1'b1; err = 1'b1;
    repeat (2) tick();
    vld = 1'b0; err = 1'b0;
    chk("both_drain", 32'(state_o), 3);
    chk("both_abort", 32'(err_abort), 1);
    chk("both_errs", err_count, 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("drain_stop", 32'(state_o), 0);
    chk("drain_stop_bits", bit_count, 2);

    // asynchronous reset mid-RUN
    launch(100, 0);
    repeat (4) tick();
    vld = 1'b1;
    repeat (3) tick();
    chk("pre_rst_bits", bit_count, 3);
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state_o), 0);
    chk("arst_outs", {27'd0, gen_en, chk_en, busy, done, err_abort}, 0);
    chk("arst_bits", bit_count, 0);
    #2 rst = 1'b0;
    vld = 1'b0;
    tick();

`ifdef BER_SEQ_TIMEOUT_EN
    // watchdog: no valid bits in RUN
    launch(100, 0);
    repeat (4) tick();
    chk("wd_run", 32'(state_o), 2);
    repeat (15) tick();
    chk("wd_15", 32'(state_o), 2);
    tick();
    chk("wd_drain", 32'(state_o), 3);
    chk("wd_flag", 32'(timeout), 1);
    repeat (4) tick();
    chk("wd_done", 32'(done), 1);
    chk("wd_flag_done", 32'(timeout), 1);
    launch(10, 0);
    chk("wd_clear", 32'(timeout), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
